// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_link_pkg
// Description : Definitions shared by the serial word link. The transmitting
//               data_program side and serial_word_receiver both use them:
//               frame width, watchdog limit and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

  // One data bit per DE2 slide switch.
  localparam int WORD_WIDTH_DEFAULT     = 18;

  // Depth of each clock-domain-crossing synchronizer.
  localparam int SYNC_STAGES_DEFAULT    = 2;

  // System clocks allowed between serial clock rising edges within a frame.
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  // Receiver frame states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECEIVE  = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_DISCARD  = 2'd3
  } rx_state_e;

endpackage : serial_link_pkg
`default_nettype wire

// File: rtl/input_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : input_synchronizer
// Description : Single-bit flip-flop chain that brings an asynchronous input
//               into the system clock domain. Every instance has the same
//               depth, so signals that arrive together stay aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module input_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] stages_q;
  logic [SYNC_STAGES-1:0] stages_d;

  // Next value of the chain: new sample enters stage 0, others shift up.
  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_comb begin
        stages_d = i_async;
      end
    end else begin : g_chain
      always_comb begin
        stages_d = {stages_q[SYNC_STAGES-2:0], i_async};
      end
    end
  endgenerate

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign o_sync = stages_q[SYNC_STAGES-1];

endmodule : input_synchronizer
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_receiver
// Description : Receives a framed, MSB-first serial word sent with its own
//               bit clock from another board. The flag input frames each
//               word. A good frame updates received_word with a word_valid
//               pulse. Short, aborted or stalled frames pulse frame_error.
//               Extra bits in a good frame set the sticky overrun flag.
//               WORD_WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  FiftyMHz_int_ref_clock,
  input  logic                  reset_n,
  input  logic                  TenMHz_input_clock,
  input  logic                  data,
  input  logic                  flag,
  output logic [WORD_WIDTH-1:0] received_word,
  output logic                  word_valid,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int c_cnt_w    = $clog2(WORD_WIDTH + 1);
  localparam int c_wd_w     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_settle_w = $clog2(SYNC_STAGES + 1);

  localparam logic [c_cnt_w-1:0]    c_cnt_full    = c_cnt_w'(WORD_WIDTH);
  localparam logic [c_wd_w-1:0]     c_wd_last     = c_wd_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_settle_w-1:0] c_settle_done = c_settle_w'(SYNC_STAGES);

  // --------------------------------------------------------------------------
  // Input synchronizers. All three have the same depth, so a data bit reaches
  // the FSM in the same cycle as the clock edge that qualified it.
  // --------------------------------------------------------------------------
  logic w_sclk_sync;
  logic w_data_sync;
  logic w_flag_sync;

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (FiftyMHz_int_ref_clock),
    .rst_n   (reset_n),
    .i_async (TenMHz_input_clock),
    .o_sync  (w_sclk_sync)
  );

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk     (FiftyMHz_int_ref_clock),
    .rst_n   (reset_n),
    .i_async (data),
    .o_sync  (w_data_sync)
  );

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_flag (
    .clk     (FiftyMHz_int_ref_clock),
    .rst_n   (reset_n),
    .i_async (flag),
    .o_sync  (w_flag_sync)
  );

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  rx_state_e               state_q,     state_d;
  logic [c_cnt_w-1:0]      cnt_q,       cnt_d;
  logic [WORD_WIDTH-1:0]   shift_q,     shift_d;
  logic [c_wd_w-1:0]       wd_q,        wd_d;
  logic [WORD_WIDTH-1:0]   word_q,      word_d;
  logic                    valid_q,     valid_d;
  logic                    ferr_q,      ferr_d;
  logic                    ovr_q,       ovr_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic [c_settle_w-1:0]   settle_q,    settle_d;
  logic                    armed_q,     armed_d;

  logic                    w_edge;
  logic                    w_settled;
  logic [c_cnt_w-1:0]      w_cnt_next;
  logic [WORD_WIDTH-1:0]   w_shift_next;

  // Rising edge of the synchronized serial clock.
  always_comb begin
    sclk_prev_d = w_sclk_sync;
    w_edge      = w_sclk_sync & ~sclk_prev_q;
  end

  // Startup settle counter. The synchronizers hold 0 after reset until they
  // have been refilled, so the flag level is not trusted until then.
  always_comb begin
    w_settled = (settle_q == c_settle_done);
    settle_d  = w_settled ? settle_q : settle_q + c_settle_w'(1);
  end

  // Frame FSM: next state, datapath updates and output pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    wd_d         = wd_q;
    word_d       = word_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
    ovr_d        = ovr_q;
    armed_d      = armed_q;
    w_cnt_next   = cnt_q;
    w_shift_next = shift_q;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (w_settled) begin
          if (!w_flag_sync) begin
            // Flag seen low after reset: the next rise is a whole frame.
            armed_d = 1'b1;
          end else if (armed_q) begin
            cnt_d   = '0;
            shift_d = '0;
            ovr_d   = 1'b0;
            state_d = ST_RECEIVE;
          end else begin
            // Flag already high when reset released: frame was cut short.
            state_d = ST_DISCARD;
          end
        end
      end

      ST_RECEIVE: begin
        wd_d = wd_q + c_wd_w'(1);
        if (w_edge) begin
          w_shift_next = {shift_q[WORD_WIDTH-2:0], w_data_sync};
          w_cnt_next   = (cnt_q == c_cnt_full) ? cnt_q : cnt_q + c_cnt_w'(1);
          wd_d         = '0;
        end
        cnt_d   = w_cnt_next;
        shift_d = w_shift_next;
        // The edge in this cycle is already counted before flag is judged.
        if (!w_flag_sync) begin
          wd_d    = '0;
          state_d = ST_IDLE;
          if (w_cnt_next == c_cnt_full) begin
            word_d  = w_shift_next;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else if (w_cnt_next == c_cnt_full) begin
          wd_d    = '0;
          state_d = ST_WAIT_END;
        end else if (!w_edge && (wd_q == c_wd_last)) begin
          wd_d    = '0;
          ferr_d  = 1'b1;
          state_d = ST_DISCARD;
        end
      end

      ST_WAIT_END: begin
        wd_d = wd_q + c_wd_w'(1);
        if (w_edge) begin
          // Word is complete; extra bits are flagged but not shifted in.
          ovr_d = 1'b1;
          wd_d  = '0;
        end
        if (!w_flag_sync) begin
          wd_d    = '0;
          word_d  = shift_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (!w_edge && (wd_q == c_wd_last)) begin
          wd_d    = '0;
          ferr_d  = 1'b1;
          state_d = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        wd_d = '0;
        if (!w_flag_sync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        wd_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge FiftyMHz_int_ref_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wd_q        <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      sclk_prev_q <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      wd_q        <= wd_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      sclk_prev_q <= sclk_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  assign received_word = word_q;
  assign word_valid    = valid_q;
  assign frame_error   = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule : serial_word_receiver
`default_nettype wire
